// File: rtl/tmr_pkg.sv
// Purpose : shared types, lane indices and voting helpers for the TMR vote monitor.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
//
// Contents:
//   mode_e      voting mode encoding (NORMAL / DEGRADED / FAIL)
//   LANE_*      replica lane indices, bit i of every lane vector is lane i
//   maj3()      single-bit 2-of-3 majority
//   mode_of()   voting mode implied by a 3-bit fault mask
package tmr_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL   = 2'd0,
    MODE_DEGRADED = 2'd1,
    MODE_FAIL     = 2'd2
  } mode_e;

  localparam int NUM_LANES = 3;
  localparam int LANE_A    = 0;
  localparam int LANE_B    = 1;
  localparam int LANE_C    = 2;

  // Two-of-three majority of one bit position.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Mode follows the number of lanes currently declared faulty.
  function automatic mode_e mode_of(input logic [NUM_LANES-1:0] mask);
    mode_e m;
    case (mask)
      3'b000:                m = MODE_NORMAL;
      3'b001, 3'b010, 3'b100: m = MODE_DEGRADED;
      default:               m = MODE_FAIL;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tmr_lane_persist.sv
// Purpose : per-lane persistence counter with sticky fault flag.
// Latency : fault rises on the same edge as the PERSIST-th consecutive disagreeing sample.
// Backpr. : none; updates only on sample or clr.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   sample      this lane is being evaluated on this cycle's sample
//   disagree    lane disagreed with the vote in this sample
//   clr         clears counter and fault flag; applied before a coincident sample
//   fault       sticky "lane declared faulty" flag
module tmr_lane_persist #(
  parameter int PERSIST = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample,
  input  logic disagree,
  input  logic clr,
  output logic fault
);

  localparam int            CW        = $clog2(PERSIST + 1);
  localparam logic [CW-1:0] PERSIST_C = CW'(PERSIST);
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          fault_q, fault_d;

  always_comb begin
    // A clear takes effect first so a coincident sample counts from zero.
    cnt_d   = clr ? '0 : cnt_q;
    fault_d = clr ? 1'b0 : fault_q;
    if (sample) begin
      if (disagree) begin
        if (cnt_d != PERSIST_C) begin
          cnt_d = cnt_d + ONE_C;
        end
      end else begin
        cnt_d = '0;
      end
      if (cnt_d == PERSIST_C) begin
        fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;

endmodule

// File: rtl/tmr_vote_monitor.sv
// Purpose : bitwise vote of three replica buses with per-lane fault tracking and mismatch reports.
// Latency : 1 cycle from accepted sample to voted_out/out_valid/mismatch/uncorrectable.
// Backpr. : samples are never stalled; report channel is a 1-entry buffer, drops set rpt_overflow.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid, lane_a/b/c        replica sample (lane_a is lane 0)
//   clr_fault                   clears fault mask, persistence counters, rpt_overflow
//   voted_out, out_valid        registered vote, 1-cycle valid pulse per sample
//   mismatch, uncorrectable     per-sample flags, aligned with out_valid
//   fault_mask, mode            sticky faulty lanes and the resulting voting mode
//   err_cnt                     saturating count of mismatching samples (reset only)
//   rpt_valid/rpt_ready         report handshake; rpt_lanes/rpt_bits describe the sample
//   rpt_overflow                sticky: a report was dropped while one was pending
module tmr_vote_monitor
  import tmr_pkg::*;
#(
  parameter int WIDTH   = 2,
  parameter int PERSIST = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] lane_a,
  input  logic [WIDTH-1:0] lane_b,
  input  logic [WIDTH-1:0] lane_c,
  input  logic             clr_fault,
  output logic [WIDTH-1:0] voted_out,
  output logic             out_valid,
  output logic             mismatch,
  output logic             uncorrectable,
  output logic [2:0]       fault_mask,
  output logic [1:0]       mode,
  output logic [CNT_W-1:0] err_cnt,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [2:0]       rpt_lanes,
  output logic [WIDTH-1:0] rpt_bits,
  output logic             rpt_overflow
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_LANES-1:0][WIDTH-1:0] lanes;
  logic [NUM_LANES-1:0]            fault_q;
  logic [NUM_LANES-1:0]            eff_mask;
  mode_e                           eff_mode;

  logic [WIDTH-1:0]     voted_c;
  logic [WIDTH-1:0]     lo_c, hi_c, diff_c;
  logic [NUM_LANES-1:0] dis_lanes_c;
  logic [WIDTH-1:0]     dis_bits_c;
  logic                 uncorr_c;
  logic                 mismatch_c;
  logic                 sample_mis;
  logic [NUM_LANES-1:0] persist_sample;

  logic [WIDTH-1:0]     voted_q, voted_d;
  logic                 out_valid_q, out_valid_d;
  logic                 mismatch_q, mismatch_d;
  logic                 uncorr_q, uncorr_d;
  logic [CNT_W-1:0]     err_q, err_d;
  logic                 rpt_valid_q, rpt_valid_d;
  logic [NUM_LANES-1:0] rpt_lanes_q, rpt_lanes_d;
  logic [WIDTH-1:0]     rpt_bits_q, rpt_bits_d;
  logic                 rpt_ovf_q, rpt_ovf_d;
  logic                 rpt_accept;

  assign lanes = {lane_c, lane_b, lane_a};

  // A coincident clr_fault is applied before the sample, so the sample is
  // voted against an empty mask.
  assign eff_mask = clr_fault ? '0 : fault_q;
  assign eff_mode = mode_of(eff_mask);

  // ---------------------------------------------------------------------------
  // Voting and disagreement attribution
  // ---------------------------------------------------------------------------
  always_comb begin
    voted_c     = lanes[LANE_A];
    lo_c        = lanes[LANE_A];
    hi_c        = lanes[LANE_B];
    diff_c      = '0;
    dis_lanes_c = '0;
    dis_bits_c  = '0;
    uncorr_c    = 1'b0;
    case (eff_mode)
      MODE_NORMAL: begin
        for (int k = 0; k < WIDTH; k++) begin
          voted_c[k] = maj3(lanes[LANE_A][k], lanes[LANE_B][k], lanes[LANE_C][k]);
        end
        // Each lane is judged independently, so two lanes wrong on
        // different bits are both flagged.
        for (int i = 0; i < NUM_LANES; i++) begin
          dis_lanes_c[i] = |(lanes[i] ^ voted_c);
          dis_bits_c     = dis_bits_c | (lanes[i] ^ voted_c);
        end
      end
      MODE_DEGRADED: begin
        // lo_c is the lower-index healthy lane and wins any tie.
        case (eff_mask)
          3'b001: begin
            lo_c = lanes[LANE_B];
            hi_c = lanes[LANE_C];
          end
          3'b010: begin
            lo_c = lanes[LANE_A];
            hi_c = lanes[LANE_C];
          end
          default: begin
            lo_c = lanes[LANE_A];
            hi_c = lanes[LANE_B];
          end
        endcase
        voted_c  = lo_c;
        diff_c   = lo_c ^ hi_c;
        uncorr_c = |diff_c;
        // With two voters neither can be trusted on a split bit, so both
        // healthy lanes are charged with the disagreement.
        dis_lanes_c = ~eff_mask & {NUM_LANES{uncorr_c}};
        dis_bits_c  = diff_c;
      end
      default: begin
        if (!eff_mask[LANE_A]) begin
          voted_c = lanes[LANE_A];
        end else if (!eff_mask[LANE_B]) begin
          voted_c = lanes[LANE_B];
        end else if (!eff_mask[LANE_C]) begin
          voted_c = lanes[LANE_C];
        end else begin
          voted_c = lanes[LANE_A];
        end
        uncorr_c = 1'b1;
      end
    endcase
  end

  assign mismatch_c = |dis_lanes_c;
  assign sample_mis = in_valid && mismatch_c;

  // Masked lanes are frozen, and FAIL mode stops all persistence tracking.
  assign persist_sample = {NUM_LANES{in_valid && (eff_mode != MODE_FAIL)}} & ~eff_mask;

  tmr_lane_persist #(.PERSIST(PERSIST)) u_persist_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .sample   (persist_sample[LANE_A]),
    .disagree (dis_lanes_c[LANE_A]),
    .clr      (clr_fault),
    .fault    (fault_q[LANE_A])
  );

  tmr_lane_persist #(.PERSIST(PERSIST)) u_persist_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .sample   (persist_sample[LANE_B]),
    .disagree (dis_lanes_c[LANE_B]),
    .clr      (clr_fault),
    .fault    (fault_q[LANE_B])
  );

  tmr_lane_persist #(.PERSIST(PERSIST)) u_persist_c (
    .clk      (clk),
    .rst_n    (rst_n),
    .sample   (persist_sample[LANE_C]),
    .disagree (dis_lanes_c[LANE_C]),
    .clr      (clr_fault),
    .fault    (fault_q[LANE_C])
  );

  // ---------------------------------------------------------------------------
  // Output register, error counter and report buffer
  // ---------------------------------------------------------------------------
  assign rpt_accept = rpt_valid_q && rpt_ready;

  always_comb begin
    voted_d     = in_valid ? voted_c : voted_q;
    out_valid_d = in_valid;
    mismatch_d  = sample_mis;
    uncorr_d    = in_valid && uncorr_c;

    err_d = err_q;
    if (sample_mis && (err_q != CNT_MAX)) begin
      err_d = err_q + CNT_ONE;
    end

    rpt_valid_d = rpt_valid_q;
    rpt_lanes_d = rpt_lanes_q;
    rpt_bits_d  = rpt_bits_q;
    rpt_ovf_d   = clr_fault ? 1'b0 : rpt_ovf_q;
    if (rpt_accept) begin
      rpt_valid_d = 1'b0;
    end
    // A consumer pop in the same cycle frees the slot, so the new entry
    // replaces the old one back-to-back instead of being dropped.
    if (sample_mis) begin
      if (!rpt_valid_q || rpt_accept) begin
        rpt_valid_d = 1'b1;
        rpt_lanes_d = dis_lanes_c;
        rpt_bits_d  = dis_bits_c;
      end else begin
        rpt_ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      voted_q     <= '0;
      out_valid_q <= 1'b0;
      mismatch_q  <= 1'b0;
      uncorr_q    <= 1'b0;
      err_q       <= '0;
      rpt_valid_q <= 1'b0;
      rpt_lanes_q <= '0;
      rpt_bits_q  <= '0;
      rpt_ovf_q   <= 1'b0;
    end else begin
      voted_q     <= voted_d;
      out_valid_q <= out_valid_d;
      mismatch_q  <= mismatch_d;
      uncorr_q    <= uncorr_d;
      err_q       <= err_d;
      rpt_valid_q <= rpt_valid_d;
      rpt_lanes_q <= rpt_lanes_d;
      rpt_bits_q  <= rpt_bits_d;
      rpt_ovf_q   <= rpt_ovf_d;
    end
  end

  assign voted_out     = voted_q;
  assign out_valid     = out_valid_q;
  assign mismatch      = mismatch_q;
  assign uncorrectable = uncorr_q;
  assign fault_mask    = fault_q;
  assign mode          = mode_of(fault_q);
  assign err_cnt       = err_q;
  assign rpt_valid     = rpt_valid_q;
  assign rpt_lanes     = rpt_lanes_q;
  assign rpt_bits      = rpt_bits_q;
  assign rpt_overflow  = rpt_ovf_q;

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Purpose : self-checking bench for tmr_vote_monitor with a reference model and output scoreboard.
// Latency : expects sample results one cycle after the capturing edge.
// Backpr. : drives rpt_ready per step to exercise hold, drop and back-to-back replacement.
module tb_tmr_vote_monitor;

  localparam int W  = 2;
  localparam int P  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [W-1:0]  lane_a, lane_b, lane_c;
  logic          clr_fault;
  logic [W-1:0]  voted_out;
  logic          out_valid, mismatch, uncorrectable;
  logic [2:0]    fault_mask;
  logic [1:0]    mode;
  logic [CW-1:0] err_cnt;
  logic          rpt_valid, rpt_ready;
  logic [2:0]    rpt_lanes;
  logic [W-1:0]  rpt_bits;
  logic          rpt_overflow;

  always #5 clk = ~clk;

  tmr_vote_monitor #(.WIDTH(W), .PERSIST(P), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .lane_a        (lane_a),
    .lane_b        (lane_b),
    .lane_c        (lane_c),
    .clr_fault     (clr_fault),
    .voted_out     (voted_out),
    .out_valid     (out_valid),
    .mismatch      (mismatch),
    .uncorrectable (uncorrectable),
    .fault_mask    (fault_mask),
    .mode          (mode),
    .err_cnt       (err_cnt),
    .rpt_valid     (rpt_valid),
    .rpt_ready     (rpt_ready),
    .rpt_lanes     (rpt_lanes),
    .rpt_bits      (rpt_bits),
    .rpt_overflow  (rpt_overflow)
  );

  typedef struct {
    int           due;
    logic [W-1:0] voted;
    logic         mis;
    logic         unc;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference state, as it should look after the most recent clock edge.
  logic [2:0]   m_mask;
  int           m_cnt[3];
  int           m_err;
  logic [W-1:0] m_voted;
  logic         m_rv, m_ovf;
  logic [2:0]   m_rl;
  logic [W-1:0] m_rb;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mask  = '0;
    m_err   = 0;
    m_voted = '0;
    m_rv    = 1'b0;
    m_ovf   = 1'b0;
    m_rl    = '0;
    m_rb    = '0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
  endtask

  function automatic logic [1:0] exp_mode(input logic [2:0] m);
    int n;
    n = int'(m[0]) + int'(m[1]) + int'(m[2]);
    return (n == 0) ? 2'd0 : (n == 1) ? 2'd1 : 2'd2;
  endfunction

  task automatic check_outputs();
    exp_t e;
    logic vld;
    vld = (sb.size() > 0) && (sb[0].due == cyc);
    chk("out_valid", out_valid, vld);
    if (vld) begin
      e = sb.pop_front();
      chk("voted_out", voted_out, e.voted);
      chk("mismatch", mismatch, e.mis);
      chk("uncorrectable", uncorrectable, e.unc);
    end else begin
      chk("voted_hold", voted_out, m_voted);
      chk("mismatch_idle", mismatch, 1'b0);
    end
    chk("fault_mask", fault_mask, m_mask);
    chk("mode", mode, exp_mode(m_mask));
    chk("err_cnt", err_cnt, m_err);
    chk("rpt_valid", rpt_valid, m_rv);
    chk("rpt_overflow", rpt_overflow, m_ovf);
    if (m_rv) begin
      chk("rpt_lanes", rpt_lanes, m_rl);
      chk("rpt_bits", rpt_bits, m_rb);
    end
  endtask

  // One clock: check what the previous edge produced, drive new inputs,
  // advance the reference model, then let the DUT capture.
  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] c, input logic clr, input logic rdy);
    logic [W-1:0] L[3];
    logic [2:0]   em, dl;
    logic [W-1:0] vt, db;
    logic         unc, mis, acc;
    int           ne, h0, h1, ones;
    @(negedge clk);
    check_outputs();
    in_valid  = v;
    lane_a    = a;
    lane_b    = b;
    lane_c    = c;
    clr_fault = clr;
    rpt_ready = rdy;

    L[0] = a; L[1] = b; L[2] = c;
    if (clr) begin
      m_mask = '0;
      m_ovf  = 1'b0;
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    end
    em  = m_mask;
    ne  = int'(em[0]) + int'(em[1]) + int'(em[2]);
    vt  = '0; dl = '0; db = '0; unc = 1'b0;
    if (ne == 0) begin
      for (int k = 0; k < W; k++) begin
        ones  = int'(a[k]) + int'(b[k]) + int'(c[k]);
        vt[k] = (ones >= 2);
      end
      for (int i = 0; i < 3; i++) begin
        if (L[i] != vt) dl[i] = 1'b1;
        db = db | (L[i] ^ vt);
      end
    end else if (ne == 1) begin
      h0 = -1; h1 = -1;
      for (int i = 0; i < 3; i++) begin
        if (!em[i]) begin
          if (h0 < 0) h0 = i;
          else        h1 = i;
        end
      end
      vt = L[h0];
      if (L[h0] != L[h1]) begin
        unc    = 1'b1;
        dl[h0] = 1'b1;
        dl[h1] = 1'b1;
        db     = L[h0] ^ L[h1];
      end
    end else begin
      vt  = !em[0] ? a : !em[1] ? b : !em[2] ? c : a;
      unc = 1'b1;
    end
    mis = (dl != 3'b000);

    if (v) begin
      sb.push_back('{cyc + 1, vt, mis, unc});
      m_voted = vt;
      if (ne < 2) begin
        for (int i = 0; i < 3; i++) begin
          if (!em[i]) begin
            if (dl[i]) m_cnt[i] = (m_cnt[i] < P) ? m_cnt[i] + 1 : P;
            else       m_cnt[i] = 0;
            if (m_cnt[i] == P) m_mask[i] = 1'b1;
          end
        end
      end
      if (mis && m_err < (1 << CW) - 1) m_err++;
    end

    acc = m_rv && rdy;
    if (v && mis) begin
      if (!m_rv || acc) begin
        m_rv = 1'b1;
        m_rl = dl;
        m_rb = db;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (acc) begin
      m_rv = 1'b0;
    end

    @(posedge clk);
    cyc++;
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_voted"}, voted_out, 0);
    chk({pfx, "_out_valid"}, out_valid, 0);
    chk({pfx, "_mismatch"}, mismatch, 0);
    chk({pfx, "_uncorr"}, uncorrectable, 0);
    chk({pfx, "_mask"}, fault_mask, 0);
    chk({pfx, "_mode"}, mode, 0);
    chk({pfx, "_err"}, err_cnt, 0);
    chk({pfx, "_rpt_valid"}, rpt_valid, 0);
    chk({pfx, "_rpt_lanes"}, rpt_lanes, 0);
    chk({pfx, "_rpt_bits"}, rpt_bits, 0);
    chk({pfx, "_rpt_ovf"}, rpt_overflow, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    lane_a    = '0;
    lane_b    = '0;
    lane_c    = '0;
    clr_fault = 1'b0;
    rpt_ready = 1'b0;
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Clean stream.
    repeat (10) step(1'b1, 2'b10, 2'b10, 2'b10, 1'b0, 1'b1);
    // Lane b persistently wrong -> masked after PERSIST samples.
    repeat (4)  step(1'b1, 2'b10, 2'b11, 2'b10, 1'b0, 1'b1);
    // DEGRADED split between a and c.
    step(1'b1, 2'b01, 2'b11, 2'b00, 1'b0, 1'b1);
    step(1'b1, 2'b10, 2'b00, 2'b10, 1'b0, 1'b1);
    // Clear without a sample, back to NORMAL.
    step(1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
    // Lane c wrong 3x, clean, 3x again: never reaches PERSIST.
    repeat (3)  step(1'b1, 2'b10, 2'b10, 2'b11, 1'b0, 1'b1);
    step(1'b1, 2'b10, 2'b10, 2'b10, 1'b0, 1'b1);
    repeat (3)  step(1'b1, 2'b10, 2'b10, 2'b11, 1'b0, 1'b1);
    step(1'b1, 2'b10, 2'b10, 2'b10, 1'b0, 1'b1);
    // Report held with rpt_ready low, second report dropped.
    step(1'b1, 2'b11, 2'b10, 2'b10, 1'b0, 1'b0);
    step(1'b1, 2'b10, 2'b11, 2'b10, 1'b0, 1'b0);
    // Pop and new mismatch in the same cycle: replaced back-to-back.
    step(1'b1, 2'b10, 2'b10, 2'b11, 1'b0, 1'b1);
    step(1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    step(1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
    // Lanes a and b wrong on different bits -> both masked, FAIL.
    repeat (4)  step(1'b1, 2'b11, 2'b00, 2'b01, 1'b0, 1'b1);
    step(1'b1, 2'b11, 2'b00, 2'b10, 1'b0, 1'b1);
    // Clear coincident with a sample: voted in NORMAL, lane b count starts at 1.
    step(1'b1, 2'b00, 2'b11, 2'b00, 1'b1, 1'b1);
    // Three more reach PERSIST only if the count above really was 1.
    repeat (3)  step(1'b1, 2'b00, 2'b11, 2'b00, 1'b0, 1'b1);
    // DEGRADED split, then asynchronous reset while its results are live.
    step(1'b1, 2'b11, 2'b10, 2'b01, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    sb.delete();
    model_reset();
    in_valid = 1'b0;
    rst_n    = 1'b1;
    // Normal operation resumes from a clean state.
    step(1'b1, 2'b01, 2'b01, 2'b00, 1'b0, 1'b1);
    step(1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    step(1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    chk("sb_drain", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tmr_vote_monitor.md
Name: tmr_vote_monitor

Overview:
- Receiving end of a triplicated netlist. Takes the three replica output buses of a TMR-hardened block (e.g. c17 outputs N22/N23 ×3), votes them bitwise and registers the result.
- Attributes each disagreement to a lane and tracks persistent faults per lane.
- Degrades voting when a lane is declared faulty, and reports mismatch events to a scrubber/logger over a valid/ready channel.

Parameters:
- WIDTH, 2, bits per replica bus.
- PERSIST, 4, consecutive mismatching samples before a lane is declared faulty (≥1).
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  lane_a/b/c hold a sample this cycle
- lane_a  in  WIDTH  replica 0 output
- lane_b  in  WIDTH  replica 1 output
- lane_c  in  WIDTH  replica 2 output
- clr_fault  in  1  clears fault mask, persistence counters and overflow flag
- voted_out  out  WIDTH  registered voted result
- out_valid  out  1  voted_out valid (1-cycle pulse per sample)
- mismatch  out  1  pulse with out_valid when any active lane disagreed
- uncorrectable  out  1  pulse with out_valid when the active lanes could not out-vote the error
- fault_mask  out  3  sticky per-lane faulty flags, bit0 = lane_a
- mode  out  2  0 NORMAL, 1 DEGRADED, 2 FAIL
- err_cnt  out  CNT_W  saturating count of samples with mismatch=1
- rpt_valid  out  1  report entry pending
- rpt_ready  in  1  consumer accepts report
- rpt_lanes  out  3  lanes that disagreed in the reported sample
- rpt_bits  out  WIDTH  bit positions that disagreed (OR over lanes)
- rpt_overflow  out  1  sticky; a report was dropped

Behaviour:
- Reset: every output 0; mode NORMAL; persistence counters 0; report buffer empty.
- Latency: one cycle. A sample accepted at edge k drives out_valid/voted_out/mismatch/uncorrectable for exactly the cycle after edge k. Without in_valid, out_valid=0 and voted_out holds its last value.
- Disagreement vector of lane i = lane_i XOR voted (WIDTH bits). Lane i "disagrees" if that vector is nonzero. Only non-masked lanes are evaluated.
- NORMAL (mask 000):
  - voted = bitwise majority(a,b,c).
  - uncorrectable never asserts.
  - Several lanes may disagree on different bits in one sample; each such lane is flagged.
- DEGRADED (exactly one mask bit set):
  - Take the two healthy lanes. Where they agree, voted = that value.
  - Where they differ, voted = the lower-index healthy lane; uncorrectable=1; both healthy lanes count as disagreeing.
- FAIL (two or more mask bits set):
  - voted = lowest-index unmasked lane; all three masked → voted = lane_a.
  - uncorrectable=1 on every sample. No further persistence counting.
- Persistence:
  - Per-lane counter, saturating at PERSIST.
  - On each accepted sample: disagreeing lane +1, agreeing lane reset to 0.
  - On reaching PERSIST, the mask bit sets in the same update. The new mask applies from the next sample.
- Mode transitions are combinational from the mask popcount: 0 → NORMAL, 1 → DEGRADED, ≥2 → FAIL. They only change on a sample edge or on clr_fault.
- err_cnt increments on every sample with mismatch=1 and stays at 2^CNT_W−1. It is cleared only by reset, not by clr_fault.
- Report channel (one-entry buffer):
  - A mismatching sample loads rpt_lanes/rpt_bits and asserts rpt_valid in the same cycle as mismatch.
  - The entry is held until rpt_valid && rpt_ready.
  - A new mismatch in the same cycle as acceptance replaces the entry with no gap and no overflow.
  - A new mismatch while the entry is pending and not accepted is dropped and sets rpt_overflow; the held entry is unchanged.
- clr_fault:
  - Clears the mask, persistence counters and rpt_overflow. Does not touch the report entry or err_cnt.
  - If it coincides with in_valid, the clear applies first: the sample is voted in NORMAL mode and counters start from 0, so a disagreeing lane ends at 1.
- Asynchronous reset mid-stream discards any in-flight sample and pending report immediately.

Decomposition:
- Shared package tmr_pkg holds:
  - mode encoding constants MODE_NORMAL/MODE_DEGRADED/MODE_FAIL;
  - lane index constants;
  - a function maj3(a,b,c).
- One sub-module, tmr_lane_persist: a per-lane saturating persistence counter plus sticky fault bit, with inputs (sample, disagree, clr) and output fault. It is instantiated three times.

Test Plan:
- All lanes 2'b10 for 10 samples → voted_out=10 one cycle after each, mismatch=0, err_cnt=0, mode NORMAL.
- lane_b=2'b11, a=c=2'b10 for 4 samples → voted 10 each, mismatch pulses ×4, rpt_lanes=010, rpt_bits=01. After the 4th sample fault_mask=010 and mode DEGRADED; err_cnt=4.
- In DEGRADED (b masked), a=01, c=00 → voted_out=01, uncorrectable=1, rpt_lanes=101, rpt_bits=01.
- Three consecutive mismatches on lane_c then one clean sample, then 3 more → fault_mask stays 000 (counter reset by the clean sample).
- Hold rpt_ready=0, drive two mismatching samples → first entry retained, rpt_overflow=1. Raise rpt_ready with a third mismatch in the same cycle → new entry loaded, rpt_valid stays 1, no extra overflow.
- Fault lanes a and b (FAIL, voted follows lane_c), then pulse clr_fault with in_valid and a=c=00, b=11 → mode NORMAL, voted 00, lane_b counter=1, mask 000, err_cnt unchanged apart from +1 for this sample; assert rst_n=0 mid-pattern → all outputs 0 immediately.
